sync_output_checker: RTL and testbench

// Receiving end of the synchronous stimulus path. A sync driver pushes expected DUT output values

---
 rtl/sync_output_checker_if.sv | 17 +
 rtl/sync_output_checker.sv | 108 ++++++++++
 tb/tb_sync_output_checker.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_output_checker_if.sv
// Expected-value push channel plus sampled DUT output, shared by the sync driver
// (master) and the output checker (slave).
interface sync_output_checker_if #(
    parameter int WIDTH = 8
);
    logic             exp_valid;
    logic             exp_ready;
    logic [WIDTH-1:0] exp_data;
    logic             exp_last;
    logic             act_valid;
    logic [WIDTH-1:0] act_data;

    modport master (output exp_valid, exp_data, exp_last, act_valid, act_data,
                    input  exp_ready);
    modport slave  (input  exp_valid, exp_data, exp_last, act_valid, act_data,
                    output exp_ready);
endinterface

// File: rtl/sync_output_checker.sv
// Buffers expected values in a FIFO, compares them in order against sampled DUT
// output, and accumulates mismatch statistics into a registered pass/done verdict.
module sync_output_checker #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  a_rst,
    input  logic                  enable,
    sync_output_checker_if.slave  bus,
    output logic [CNT_W-1:0]      compare_cnt,
    output logic [CNT_W-1:0]      mismatch_cnt,
    output logic [CNT_W-1:0]      first_err_idx,
    output logic [WIDTH-1:0]      first_err_exp,
    output logic [WIDTH-1:0]      first_err_act,
    output logic                  underflow,
    output logic                  done,
    output logic                  pass
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    logic [WIDTH:0]   mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count, count_nopop, count_nxt;
    logic [1:0]       state, state_nxt;
    logic             ready_q, ready_nxt;
    logic             empty, push, cmp, pop, mis, head_last;
    logic [WIDTH-1:0] head_data;
    logic [CNT_W-1:0] cmp_cnt_nxt, mis_cnt_nxt;
    logic             uf_nxt, done_nxt;

    assign bus.exp_ready = ready_q;

    always_comb begin
        {head_last, head_data} = mem[rd_ptr];
        empty = (count == '0);
        push  = bus.exp_valid && ready_q && (state != ST_DONE);
        cmp   = (state == ST_RUN) && enable && bus.act_valid;
        pop   = cmp && !empty;
        mis   = cmp && (empty || (head_data != bus.act_data));

        state_nxt = state;
        case (state)
            ST_IDLE: if (enable) state_nxt = ST_RUN;
            ST_RUN: begin
                if (pop && head_last) state_nxt = ST_DONE;
                else if (!enable)     state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_DONE;
        endcase

        // Readiness is judged on the post-push, pre-pop occupancy so a full FIFO
        // never overflows even though ready is registered.
        count_nopop = count + (AW+1)'(push);
        count_nxt   = count_nopop - (AW+1)'(pop);
        ready_nxt   = (count_nopop != FULL_CNT) && (state_nxt != ST_DONE);

        cmp_cnt_nxt = (pop && compare_cnt != CNT_MAX) ? compare_cnt + CNT_W'(1) : compare_cnt;
        mis_cnt_nxt = (mis && mismatch_cnt != CNT_MAX) ? mismatch_cnt + CNT_W'(1) : mismatch_cnt;
        uf_nxt      = underflow || (cmp && empty);
        done_nxt    = done || (pop && head_last);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.exp_last, bus.exp_data};
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state         <= ST_IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            ready_q       <= 1'b0;
            compare_cnt   <= '0;
            mismatch_cnt  <= '0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_act <= '0;
            underflow     <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            ready_q      <= ready_nxt;
            compare_cnt  <= cmp_cnt_nxt;
            mismatch_cnt <= mis_cnt_nxt;
            underflow    <= uf_nxt;
            done         <= done_nxt;
            pass         <= done_nxt && (mis_cnt_nxt == '0) && !uf_nxt;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (mis && mismatch_cnt == '0) begin
                first_err_idx <= compare_cnt;
                first_err_exp <= empty ? '0 : head_data;
                first_err_act <= bus.act_data;
            end
        end
    end
endmodule

// File: tb/tb_sync_output_checker.sv
// Randomized and directed bench for sync_output_checker against a queue-based model.
module tb_sync_output_checker;
    logic clk = 1'b0;
    logic a_rst = 1'b1;
    logic enable = 1'b0, enable2 = 1'b0;
    always #5 clk = ~clk;

    sync_output_checker_if #(.WIDTH(8)) ifc ();
    sync_output_checker_if #(.WIDTH(8)) ifc2 ();

    logic [15:0] compare_cnt, mismatch_cnt, first_err_idx;
    logic [7:0]  first_err_exp, first_err_act;
    logic        underflow, done, pass;
    logic [1:0]  compare_cnt2, mismatch_cnt2, first_err_idx2;
    logic [7:0]  first_err_exp2, first_err_act2;
    logic        underflow2, done2, pass2;

    sync_output_checker #(.WIDTH(8), .DEPTH(16), .CNT_W(16)) dut (
        .clk(clk), .a_rst(a_rst), .enable(enable), .bus(ifc),
        .compare_cnt(compare_cnt), .mismatch_cnt(mismatch_cnt), .first_err_idx(first_err_idx),
        .first_err_exp(first_err_exp), .first_err_act(first_err_act),
        .underflow(underflow), .done(done), .pass(pass));

    sync_output_checker #(.WIDTH(8), .DEPTH(16), .CNT_W(2)) dut2 (
        .clk(clk), .a_rst(a_rst), .enable(enable2), .bus(ifc2),
        .compare_cnt(compare_cnt2), .mismatch_cnt(mismatch_cnt2), .first_err_idx(first_err_idx2),
        .first_err_exp(first_err_exp2), .first_err_act(first_err_act2),
        .underflow(underflow2), .done(done2), .pass(pass2));

    int errors = 0, checks = 0;

    // Reference model: pending expectations and running statistics.
    logic [7:0] mq[$];
    bit         mlq[$];
    int         m_cmp, m_mis, m_fidx, m_fexp, m_fact;
    bit         m_uf, m_done;

    function automatic void model_clear();
        mq.delete(); mlq.delete();
        m_cmp = 0; m_mis = 0; m_fidx = 0; m_fexp = 0; m_fact = 0;
        m_uf = 0; m_done = 0;
    endfunction

    function automatic void model_act(input logic [7:0] a);
        logic [7:0] h;
        bit l;
        if (m_done) return;
        if (mq.size() == 0) begin
            if (m_mis == 0) begin m_fidx = m_cmp; m_fexp = 0; m_fact = a; end
            m_uf = 1; m_mis++;
        end else begin
            h = mq.pop_front(); l = mlq.pop_front();
            if (h != a) begin
                if (m_mis == 0) begin m_fidx = m_cmp; m_fexp = h; m_fact = a; end
                m_mis++;
            end
            m_cmp++;
            if (l) m_done = 1;
        end
    endfunction

    function automatic logic [66:0] dut_status();
        return {compare_cnt, mismatch_cnt, first_err_idx, first_err_exp, first_err_act,
                underflow, done, pass};
    endfunction

    function automatic logic [66:0] model_status();
        return {16'(m_cmp), 16'(m_mis), 16'(m_fidx), 8'(m_fexp), 8'(m_fact),
                m_uf, m_done, m_done && m_mis == 0 && !m_uf};
    endfunction

    task automatic idle_bus();
        ifc.exp_valid = 0; ifc.exp_data = 0; ifc.exp_last = 0; ifc.act_valid = 0; ifc.act_data = 0;
        ifc2.exp_valid = 0; ifc2.exp_data = 0; ifc2.exp_last = 0; ifc2.act_valid = 0; ifc2.act_data = 0;
    endtask

    task automatic push(input logic [7:0] d, input bit l);
        int n = 0;
        ifc.exp_valid = 1; ifc.exp_data = d; ifc.exp_last = l;
        while (!ifc.exp_ready && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (n == 50) begin errors++; $display("FAIL push_timeout: exp_ready=%b want 1", ifc.exp_ready); end
        else begin @(negedge clk); mq.push_back(d); mlq.push_back(l); end
        ifc.exp_valid = 0;
    endtask

    task automatic act(input logic [7:0] a);
        ifc.act_valid = 1; ifc.act_data = a;
        @(negedge clk);
        ifc.act_valid = 0;
        model_act(a);
    endtask

    task automatic start();
        enable = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        a_rst = 1; enable = 0; enable2 = 0; idle_bus();
        @(negedge clk);
        checks++;
        if ({ifc.exp_ready, ifc2.exp_ready, dut_status()} !== '0) begin
            errors++; $display("FAIL reset_state: got rdy=%b status=%h want all 0", ifc.exp_ready, dut_status());
        end
        checks++;
        if ({compare_cnt2, mismatch_cnt2, first_err_idx2, first_err_exp2, first_err_act2,
             underflow2, done2, pass2} !== '0) begin
            errors++; $display("FAIL reset_state2: cnt=%0d mis=%0d want 0", compare_cnt2, mismatch_cnt2);
        end
        a_rst = 0;
        @(negedge clk);
        model_clear();
    endtask

    task automatic test_basic();
        test_reset();
        for (int i = 1; i <= 4; i++) push(8'(i), i == 4);
        start();
        for (int i = 1; i <= 4; i++) act(8'(i));
        checks++;
        if ({compare_cnt, mismatch_cnt, done, pass} !== {16'd4, 16'd0, 1'b1, 1'b1}) begin
            errors++; $display("FAIL basic: cnt=%0d mis=%0d done=%b pass=%b want 4 0 1 1",
                               compare_cnt, mismatch_cnt, done, pass);
        end
        checks++;
        if (ifc.exp_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_done: got %b want 0", ifc.exp_ready); end
    endtask

    task automatic test_mismatch();
        test_reset();
        push(8'd5, 0); push(8'd6, 0); push(8'd7, 1);
        start();
        act(8'd5); act(8'd9); act(8'd7);
        checks++;
        if ({mismatch_cnt, first_err_idx, first_err_exp, first_err_act, done, pass} !==
            {16'd1, 16'd1, 8'd6, 8'd9, 1'b1, 1'b0}) begin
            errors++; $display("FAIL mismatch: mis=%0d idx=%0d exp=%0d act=%0d done=%b pass=%b want 1 1 6 9 1 0",
                               mismatch_cnt, first_err_idx, first_err_exp, first_err_act, done, pass);
        end
    endtask

    task automatic test_underflow();
        test_reset();
        start();
        act(8'd3);
        checks++;
        if ({underflow, mismatch_cnt, first_err_exp, first_err_act, compare_cnt, done, pass} !==
            {1'b1, 16'd1, 8'd0, 8'd3, 16'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL underflow: uf=%b mis=%0d fexp=%0d fact=%0d cnt=%0d want 1 1 0 3 0",
                               underflow, mismatch_cnt, first_err_exp, first_err_act, compare_cnt);
        end
    endtask

    task automatic test_full();
        logic [7:0] vals [20];
        int pi = 16, acts = 0, n = 0;
        bit will_push;
        test_reset();
        for (int i = 0; i < 20; i++) vals[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) push(vals[i], 0);
        ifc.exp_valid = 1; ifc.exp_data = vals[16]; ifc.exp_last = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ifc.exp_ready !== 1'b0) begin errors++; $display("FAIL full_ready: cyc %0d got %b want 0", i, ifc.exp_ready); end
            @(negedge clk);
        end
        start();
        while (acts < 20 && n < 200) begin
            if (pi < 20) begin
                ifc.exp_valid = 1; ifc.exp_data = vals[pi]; ifc.exp_last = (pi == 19);
            end else ifc.exp_valid = 0;
            ifc.act_valid = (mq.size() > 0);
            ifc.act_data  = (mq.size() > 0) ? mq[0] : 8'h00;
            will_push = ifc.exp_valid && ifc.exp_ready;
            @(negedge clk);
            if (ifc.act_valid) begin model_act(ifc.act_data); acts++; end
            if (will_push) begin mq.push_back(vals[pi]); mlq.push_back(pi == 19); pi++; end
            n++;
        end
        idle_bus();
        checks++;
        if (pi != 20 || acts != 20) begin errors++; $display("FAIL full_drain: pushed=%0d acts=%0d want 20 20", pi, acts); end
        checks++;
        if (dut_status() !== model_status()) begin
            errors++; $display("FAIL full_status: got %h want %h", dut_status(), model_status());
        end
        checks++;
        if ({compare_cnt, pass} !== {16'd20, 1'b1}) begin
            errors++; $display("FAIL full_result: cnt=%0d pass=%b want 20 1", compare_cnt, pass);
        end
    endtask

    task automatic test_pause_and_reset();
        test_reset();
        for (int i = 10; i <= 13; i++) push(8'(i), i == 13);
        start();
        act(8'd10); act(8'd11);
        enable = 0;
        ifc.act_valid = 1; ifc.act_data = 8'hEE;
        repeat (3) @(negedge clk);
        ifc.act_valid = 0;
        checks++;
        if ({compare_cnt, mismatch_cnt, underflow, done} !== {16'd2, 16'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL pause_hold: cnt=%0d mis=%0d uf=%b done=%b want 2 0 0 0",
                               compare_cnt, mismatch_cnt, underflow, done);
        end
        start();
        act(8'd12); act(8'd13);
        checks++;
        if (dut_status() !== model_status() || pass !== 1'b1) begin
            errors++; $display("FAIL pause_resume: got %h want %h", dut_status(), model_status());
        end
        test_reset();
        push(8'd1, 0); push(8'd2, 0);
        start();
        act(8'd7);
        a_rst = 1;
        #1;
        checks++;
        if ({ifc.exp_ready, dut_status()} !== '0) begin
            errors++; $display("FAIL mid_reset: rdy=%b status=%h want all 0", ifc.exp_ready, dut_status());
        end
        @(negedge clk);
        checks++;
        if (ifc.exp_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready: got %b want 0", ifc.exp_ready); end
        enable = 0;
        a_rst = 0;
        @(negedge clk);
        model_clear();
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int n;
            logic [7:0] a;
            test_reset();
            n = $urandom_range(3, 14);
            for (int i = 0; i < n; i++) push(8'($urandom), i == n - 1);
            start();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                a = mq[0];
                if ($urandom_range(0, 3) == 0) a = a ^ (8'd1 << $urandom_range(0, 7));
                act(a);
                checks++;
                if (compare_cnt !== 16'(m_cmp)) begin
                    errors++; $display("FAIL rnd_cnt: it %0d got %0d want %0d", it, compare_cnt, m_cmp);
                end
            end
            checks++;
            if (dut_status() !== model_status()) begin
                errors++; $display("FAIL rnd_status: it %0d got %h want %h", it, dut_status(), model_status());
            end
        end
    endtask

    task automatic test_saturation();
        int n;
        test_reset();
        for (int i = 0; i < 5; i++) begin
            n = 0;
            ifc2.exp_valid = 1; ifc2.exp_data = 8'(i); ifc2.exp_last = (i == 4);
            while (!ifc2.exp_ready && n < 50) begin @(negedge clk); n++; end
            @(negedge clk);
        end
        ifc2.exp_valid = 0;
        enable2 = 1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            ifc2.act_valid = 1; ifc2.act_data = 8'(i) ^ 8'hFF;
            @(negedge clk);
        end
        ifc2.act_valid = 0;
        checks++;
        if ({mismatch_cnt2, compare_cnt2, first_err_idx2, first_err_exp2, first_err_act2, done2, pass2} !==
            {2'd3, 2'd3, 2'd0, 8'h00, 8'hFF, 1'b1, 1'b0}) begin
            errors++; $display("FAIL saturation: mis=%0d cnt=%0d idx=%0d done=%b pass=%b want 3 3 0 1 0",
                               mismatch_cnt2, compare_cnt2, first_err_idx2, done2, pass2);
        end
        enable2 = 0;
    endtask

    initial begin
        idle_bus();
        test_reset();
        test_basic();
        test_mismatch();
        test_underflow();
        test_full();
        test_pause_and_reset();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
